// File: rtl/accel_spi_reader_if.sv
// 4-wire SPI bus between the accelerometer reader (master) and the ADXL345 (slave).
interface accel_spi_reader_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_sdi;
  logic spi_sdo;

  modport master (output spi_sclk, output spi_cs_n, output spi_sdi, input spi_sdo);
  modport slave  (input spi_sclk, input spi_cs_n, input spi_sdi, output spi_sdo);
endinterface

// File: rtl/accel_spi_reader.sv
// ADXL345 SPI reader: configures the sensor once, then polls X/Y/Z in mode 3 and emits 10-bit offset-binary axes.
// Optional ACCEL_AVG_EN: outputs become a running average of the last four samples per axis.
module accel_spi_reader #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int SPI_FREQ    = 1_000_000,
  parameter int SAMPLE_RATE = 100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  accel_spi_reader_if.master        spi,
  output logic [9:0]                x_out,
  output logic [9:0]                y_out,
  output logic [9:0]                z_out,
  output logic                      data_valid,
  output logic                      cfg_done
);

  localparam int CLK_DIV    = CLK_FREQ / (2 * SPI_FREQ);
  localparam int SAMPLE_DIV = CLK_FREQ / SAMPLE_RATE;
  localparam int CW         = 16;
  localparam int SW         = $clog2(SAMPLE_DIV);

  localparam logic [CW-1:0] HALF_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST    = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] RST_LAST    = CW'(1023);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_DIV - 1);

  localparam logic [2:0] ST_RST_WAIT = 3'd0;
  localparam logic [2:0] ST_CFG_FMT  = 3'd1;
  localparam logic [2:0] ST_CFG_PWR  = 3'd2;
  localparam logic [2:0] ST_IDLE     = 3'd3;
  localparam logic [2:0] ST_READ     = 3'd4;
  localparam logic [2:0] ST_UPDATE   = 3'd5;

  // Every transaction walks GAP (CS high) -> SETUP -> BITS -> HOLD (CS low).
  localparam logic [1:0] PH_GAP   = 2'd0;
  localparam logic [1:0] PH_SETUP = 2'd1;
  localparam logic [1:0] PH_BITS  = 2'd2;
  localparam logic [1:0] PH_HOLD  = 2'd3;

  logic [2:0]    state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]   tx_q, tx_d;
  logic [47:0]   rx_q, rx_d;
  logic [SW-1:0] samp_cnt_q, samp_cnt_d;
  logic          cs_n_q, cs_n_d;
  logic          sclk_q, sclk_d;
  logic          sdi_q, sdi_d;
  logic          cfg_done_q, cfg_done_d;
  logic          data_valid_q, data_valid_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic [9:0]    z_q, z_d;

  logic          tick;
  logic [5:0]    last_bit;
  logic [2:0][9:0] smp;
  logic [2:0][9:0] upd;
  logic          unused_b1_bits;

  assign tick     = cfg_done_q && (samp_cnt_q == SAMPLE_LAST);
  assign last_bit = (state_q == ST_READ) ? 6'd55 : 6'd15;

  // rx_q holds X0 X1 Y0 Y1 Z0 Z1; flipping bit 9 of the 10-bit two's complement adds 512.
  assign smp[0] = {~rx_q[33], rx_q[32], rx_q[47:40]};
  assign smp[1] = {~rx_q[17], rx_q[16], rx_q[31:24]};
  assign smp[2] = {~rx_q[1],  rx_q[0],  rx_q[15:8]};
  assign unused_b1_bits = ^{rx_q[39:34], rx_q[23:18], rx_q[7:2]};

`ifdef ACCEL_AVG_EN
  // The three previous samples plus the incoming one form the 4-sample window.
  logic [2:0][2:0][9:0] hist_q, hist_d;
  logic [2:0][11:0]     sum;

  always_comb begin
    hist_d = hist_q;
    sum    = '0;
    upd    = '0;
    for (int a = 0; a < 3; a++) begin
      sum[a] = 12'(smp[a]) + 12'(hist_q[a][0]) + 12'(hist_q[a][1]) + 12'(hist_q[a][2]);
      upd[a] = sum[a][11:2];
      if (state_q == ST_UPDATE) begin
        hist_d[a][0] = smp[a];
        hist_d[a][1] = hist_q[a][0];
        hist_d[a][2] = hist_q[a][1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= {9{10'd512}};
    end else begin
      hist_q <= hist_d;
    end
  end
`else
  assign upd = smp;
`endif

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    cs_n_d       = cs_n_q;
    sclk_d       = sclk_q;
    sdi_d        = sdi_q;
    cfg_done_d   = cfg_done_q;
    data_valid_d = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    z_d          = z_q;
    samp_cnt_d   = '0;

    if (cfg_done_q) begin
      samp_cnt_d = tick ? '0 : samp_cnt_q + 1'b1;
    end

    case (state_q)
      ST_RST_WAIT: begin
        if (div_cnt_q == RST_LAST) begin
          state_d   = ST_CFG_FMT;
          phase_d   = PH_GAP;
          div_cnt_d = '0;
          tx_d      = 16'h3100;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      ST_CFG_FMT, ST_CFG_PWR, ST_READ: begin
        div_cnt_d = div_cnt_q + 1'b1;
        case (phase_q)
          PH_GAP: begin
            if (div_cnt_q == GAP_LAST) begin
              phase_d   = PH_SETUP;
              div_cnt_d = '0;
              cs_n_d    = 1'b0;
              bit_cnt_d = '0;
            end
          end
          PH_SETUP: begin
            if (div_cnt_q == HALF_LAST) begin
              phase_d   = PH_BITS;
              div_cnt_d = '0;
              sclk_d    = 1'b0;
              sdi_d     = tx_q[15];
              tx_d      = {tx_q[14:0], 1'b0};
            end
          end
          PH_BITS: begin
            // Mid-bit rising edge samples MISO; the final rising edge starts the CS hold.
            if (div_cnt_q == HALF_LAST) begin
              sclk_d = 1'b1;
              rx_d   = {rx_q[46:0], spi.spi_sdo};
              if (bit_cnt_q == last_bit) begin
                phase_d   = PH_HOLD;
                div_cnt_d = '0;
              end
            end else if (div_cnt_q == BIT_LAST) begin
              div_cnt_d = '0;
              bit_cnt_d = bit_cnt_q + 1'b1;
              sclk_d    = 1'b0;
              sdi_d     = tx_q[15];
              tx_d      = {tx_q[14:0], 1'b0};
            end
          end
          PH_HOLD: begin
            if (div_cnt_q == HALF_LAST) begin
              cs_n_d    = 1'b1;
              sdi_d     = 1'b0;
              div_cnt_d = '0;
              phase_d   = PH_GAP;
              case (state_q)
                ST_CFG_FMT: begin
                  state_d = ST_CFG_PWR;
                  tx_d    = 16'h2D08;
                end
                ST_CFG_PWR: begin
                  state_d    = ST_IDLE;
                  cfg_done_d = 1'b1;
                end
                default: state_d = ST_UPDATE;
              endcase
            end
          end
          default: phase_d = PH_GAP;
        endcase
      end

      ST_IDLE: begin
        if (tick && enable) begin
          state_d   = ST_READ;
          phase_d   = PH_GAP;
          div_cnt_d = '0;
          tx_d      = 16'hF200;
        end
      end

      ST_UPDATE: begin
        state_d      = ST_IDLE;
        data_valid_d = 1'b1;
        x_d          = upd[0];
        y_d          = upd[1];
        z_d          = upd[2];
      end

      default: state_d = ST_RST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RST_WAIT;
      phase_q      <= PH_GAP;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      samp_cnt_q   <= '0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b1;
      sdi_q        <= 1'b0;
      cfg_done_q   <= 1'b0;
      data_valid_q <= 1'b0;
      x_q          <= 10'd512;
      y_q          <= 10'd512;
      z_q          <= 10'd512;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      samp_cnt_q   <= samp_cnt_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      sdi_q        <= sdi_d;
      cfg_done_q   <= cfg_done_d;
      data_valid_q <= data_valid_d;
      x_q          <= x_d;
      y_q          <= y_d;
      z_q          <= z_d;
    end
  end

  assign spi.spi_cs_n = cs_n_q;
  assign spi.spi_sclk = sclk_q;
  assign spi.spi_sdi  = sdi_q;
  assign x_out        = x_q;
  assign y_out        = y_q;
  assign z_out        = z_q;
  assign data_valid   = data_valid_q;
  assign cfg_done     = cfg_done_q;

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: ADXL345 slave model in mode 3, random axis bytes checked against an arithmetic reference.
module tb_accel_spi_reader;

  localparam int CLK_DIV    = 2;
  localparam int SAMPLE_DIV = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [9:0] x_out, y_out, z_out;
  logic       data_valid, cfg_done;

  accel_spi_reader_if spi();

  accel_spi_reader #(
    .CLK_FREQ    (50_000_000),
    .SPI_FREQ    (12_500_000),
    .SAMPLE_RATE (25_000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .spi        (spi),
    .x_out      (x_out),
    .y_out      (y_out),
    .z_out      (z_out),
    .data_valid (data_valid),
    .cfg_done   (cfg_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [47:0] resp = '0;
  int exp_x = 512, exp_y = 512, exp_z = 512;
`ifdef ACCEL_AVG_EN
  int hist[3][4];
`endif

  // Sensor model: shifts the response out on falling SCLK, captures MOSI on rising SCLK.
  logic [55:0] slv_tx = '0;
  logic [55:0] slv_rx = '0;
  int          slv_rises = 0;
  logic        slv_cs_prev = 1'b1;
  logic        slv_sclk_prev = 1'b1;
  int          tr_bits[$];
  logic [15:0] tr_head[$];
  logic        cs_sclk[$];

  always @(spi.spi_cs_n or spi.spi_sclk) begin
    logic [55:0] tmp;
    if (slv_cs_prev === 1'b1 && spi.spi_cs_n === 1'b0) begin
      slv_tx      = {8'h00, resp};
      slv_rx      = '0;
      slv_rises   = 0;
      spi.spi_sdo = 1'b0;
      cs_sclk.push_back(spi.spi_sclk);
    end else if (spi.spi_cs_n === 1'b0 && slv_sclk_prev === 1'b1 && spi.spi_sclk === 1'b0) begin
      spi.spi_sdo = slv_tx[55];
      slv_tx      = {slv_tx[54:0], 1'b0};
    end else if (spi.spi_cs_n === 1'b0 && slv_sclk_prev === 1'b0 && spi.spi_sclk === 1'b1) begin
      slv_rx    = {slv_rx[54:0], spi.spi_sdi};
      slv_rises = slv_rises + 1;
    end
    if (slv_cs_prev === 1'b0 && spi.spi_cs_n === 1'b1) begin
      tmp = slv_rx >> ((slv_rises >= 16) ? (slv_rises - 16) : 0);
      tr_bits.push_back(slv_rises);
      tr_head.push_back(tmp[15:0]);
    end
    slv_cs_prev   = spi.spi_cs_n;
    slv_sclk_prev = spi.spi_sclk;
  end

  // Cycle-level monitor sampled on the inactive clock edge.
  int   cyc = 0, cs_falls = 0, dv_count = 0;
  int   cs_fall_cyc = 0, cs_rise_cyc = 0, dv_cyc = 0, setup_cyc = -1;
  logic mon_cs_prev = 1'b1, mon_sclk_prev = 1'b1;
  bit   await_fall = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mon_cs_prev === 1'b1 && spi.spi_cs_n === 1'b0) begin
      cs_falls    = cs_falls + 1;
      cs_fall_cyc = cyc;
      await_fall  = 1'b1;
    end
    if (mon_cs_prev === 1'b0 && spi.spi_cs_n === 1'b1) cs_rise_cyc = cyc;
    if (await_fall && mon_sclk_prev === 1'b1 && spi.spi_sclk === 1'b0) begin
      setup_cyc  = cyc - cs_fall_cyc;
      await_fall = 1'b0;
    end
    if (data_valid === 1'b1) begin
      dv_count = dv_count + 1;
      dv_cyc   = cyc;
    end
    mon_cs_prev   = spi.spi_cs_n;
    mon_sclk_prev = spi.spi_sclk;
  end

  function automatic int conv(input int lo, input int hi);
    int raw = (hi % 4) * 256 + lo;
    if (raw >= 512) raw = raw - 1024;
    return raw + 512;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
`ifdef ACCEL_AVG_EN
    for (int a = 0; a < 3; a++)
      for (int k = 0; k < 4; k++) hist[a][k] = 512;
`endif
    exp_x = 512;
    exp_y = 512;
    exp_z = 512;
  endtask

  // Loads the sensor response for the next read and advances the reference model by one sample.
  task automatic applyStimulus(input logic [47:0] bytes);
    int s[3];
    int e[3];
    resp = bytes;
    s[0] = conv(int'(bytes[47:40]), int'(bytes[39:32]));
    s[1] = conv(int'(bytes[31:24]), int'(bytes[23:16]));
    s[2] = conv(int'(bytes[15:8]),  int'(bytes[7:0]));
    for (int a = 0; a < 3; a++) begin
`ifdef ACCEL_AVG_EN
      int sum = 0;
      for (int k = 3; k > 0; k--) hist[a][k] = hist[a][k-1];
      hist[a][0] = s[a];
      for (int k = 0; k < 4; k++) sum = sum + hist[a][k];
      e[a] = sum / 4;
`else
      e[a] = s[a];
`endif
    end
    exp_x = e[0];
    exp_y = e[1];
    exp_z = e[2];
  endtask

  task automatic waitCfg(input string tag);
    int n = 0;
    while (cfg_done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    #1;
    checkOutput({tag, " cfg_done"}, cfg_done, 1);
    checkOutput({tag, " write count"}, tr_bits.size(), 2);
    if (tr_bits.size() >= 2) begin
      checkOutput({tag, " fmt bits"}, tr_bits[0], 16);
      checkOutput({tag, " fmt word"}, tr_head[0], 16'h3100);
      checkOutput({tag, " pwr bits"}, tr_bits[1], 16);
      checkOutput({tag, " pwr word"}, tr_head[1], 16'h2D08);
    end
    checkOutput({tag, " sclk idle high"}, (cs_sclk.size() > 0) ? cs_sclk[0] : 1'b0, 1);
    checkOutput({tag, " cs setup"}, setup_cyc, CLK_DIV);
    checkOutput({tag, " x held 512"}, x_out, 512);
    checkOutput({tag, " z held 512"}, z_out, 512);
  endtask

  task automatic checkRead(input string tag);
    int n = 0;
    while (data_valid !== 1'b1 && n < 3 * SAMPLE_DIV) begin
      @(negedge clk);
      n++;
    end
    #1;
    checkOutput({tag, " data_valid"}, data_valid, 1);
    checkOutput({tag, " x_out"}, x_out, exp_x);
    checkOutput({tag, " y_out"}, y_out, exp_y);
    checkOutput({tag, " z_out"}, z_out, exp_z);
    checkOutput({tag, " dv after cs high"}, dv_cyc - cs_rise_cyc, 1);
    checkOutput({tag, " read bits"}, (tr_bits.size() > 0) ? tr_bits[$] : 0, 56);
    checkOutput({tag, " read cmd"}, (tr_head.size() > 0) ? tr_head[$] : 16'h0, 16'hF200);
    @(negedge clk);
    #1;
    checkOutput({tag, " dv single pulse"}, data_valid, 0);
  endtask

  task automatic waitCsFall(input string tag);
    int n0 = cs_falls;
    int n  = 0;
    while (cs_falls == n0 && n < 3 * SAMPLE_DIV) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " read started"}, (cs_falls != n0) ? 1 : 0, 1);
  endtask

  initial begin
    int first_fall;
    int n1, d1, en_cyc;

    rst    = 1'b1;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("reset x_out", x_out, 512);
    checkOutput("reset y_out", y_out, 512);
    checkOutput("reset z_out", z_out, 512);
    checkOutput("reset data_valid", data_valid, 0);
    checkOutput("reset cfg_done", cfg_done, 0);
    checkOutput("reset cs_n", spi.spi_cs_n, 1);
    checkOutput("reset sclk", spi.spi_sclk, 1);
    checkOutput("reset sdi", spi.spi_sdi, 0);
    resetModel();
    tr_bits.delete();
    tr_head.delete();
    cs_sclk.delete();
    rst = 1'b0;

    $display("[TB] configuration after reset");
    waitCfg("cfg1");

    applyStimulus(48'hFF_01_00_02_FF_03);
    checkRead("read_fixed");
    first_fall = cs_fall_cyc;

    applyStimulus(48'h00_00_00_00_00_00);
    checkRead("read_zero");

    applyStimulus(48'h00_FD_00_00_00_00);
    checkRead("read_b1_upper");

    for (int i = 0; i < 4; i++) begin
      applyStimulus({16'($urandom), $urandom});
      checkRead($sformatf("read_rand%0d", i));
    end

    $display("[TB] enable dropped during a read");
    applyStimulus({16'($urandom), $urandom});
    waitCsFall("en_off");
    enable = 1'b0;
    checkRead("read_en_fall");
    n1 = cs_falls;
    d1 = dv_count;
    repeat (5000) @(negedge clk);
    #1;
    checkOutput("disabled cs quiet", cs_falls, n1);
    checkOutput("disabled no dv", dv_count, d1);
    checkOutput("disabled x hold", x_out, exp_x);
    checkOutput("disabled y hold", y_out, exp_y);

    applyStimulus({16'($urandom), $urandom});
    en_cyc = cyc;
    enable = 1'b1;
    checkRead("read_resume");
    checkOutput("resume on tick grid", (cs_fall_cyc - first_fall) % SAMPLE_DIV, 0);
    checkOutput("resume at next tick", ((cs_fall_cyc - en_cyc) <= SAMPLE_DIV + 3 * CLK_DIV) ? 1 : 0, 1);

    $display("[TB] reset in the middle of a read");
    applyStimulus({16'($urandom), $urandom});
    waitCsFall("mid_rst");
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("midrst cs_n", spi.spi_cs_n, 1);
    checkOutput("midrst sclk", spi.spi_sclk, 1);
    checkOutput("midrst sdi", spi.spi_sdi, 0);
    checkOutput("midrst cfg_done", cfg_done, 0);
    checkOutput("midrst x_out", x_out, 512);
    checkOutput("midrst y_out", y_out, 512);
    checkOutput("midrst z_out", z_out, 512);
    rst = 1'b0;
    resetModel();
    tr_bits.delete();
    tr_head.delete();
    cs_sclk.delete();

    waitCfg("cfg2");
    applyStimulus({16'($urandom), $urandom});
    checkRead("read_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/accel_spi_reader.md
# accel_spi_reader

Reads the on-board ADXL345 accelerometer over 4-wire SPI and produces three 10-bit unsigned axis values for the arm top level, in the same format as the position memory outputs. It sits upstream of the source multiplexer: its outputs feed the X/Y/Z accelerometer inputs. The top level then forwards the selected values to the servo PWM stage, the displays and the LEDs. After reset it configures the sensor once, then polls all three axes at a fixed rate while enabled.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency, Hz.
- SPI_FREQ, 1_000_000: SCLK frequency, Hz. CLK_DIV = CLK_FREQ/(2*SPI_FREQ) must be ≥ 2.
- SAMPLE_RATE, 100: axis reads per second. SAMPLE_DIV = CLK_FREQ/SAMPLE_RATE.

Ports:
- clk  in  1: system clock. One clock domain only.
- rst  in  1: reset, synchronous and active-high. Driven by the one-shot reset pulse.
- enable  in  1: starts new reads when high. Connected to select_source.
- spi_sdo  in  1: MISO from the sensor.
- spi_sclk  out  1: SPI clock. Mode 3 (CPOL=1, CPHA=1).
- spi_cs_n  out  1: chip select, active-low.
- spi_sdi  out  1: MOSI to the sensor.
- x_out, y_out, z_out  out  10: offset-binary axis values; 512 = 0 g.
- data_valid  out  1: one-cycle pulse when all three axis outputs update.
- cfg_done  out  1: high once sensor configuration is complete.

## Operation
- State machine: RST_WAIT → CFG_FMT → CFG_PWR → IDLE → READ → UPDATE → IDLE.
- RST_WAIT: waits 1024 clk cycles with CS high.
- CFG_FMT: 16-bit write transaction, 0x31 then 0x00.
  - DATA_FORMAT register: 4-wire SPI, ±2 g, 10-bit, right-justified.
- CFG_PWR: 16-bit write transaction, 0x2D then 0x08 (measure mode). cfg_done rises on completion.
- IDLE: the sample counter counts 0..SAMPLE_DIV-1 continuously from cfg_done. At wrap, if enable=1, go to READ; otherwise stay in IDLE.
- READ: 56-bit transaction.
  - Command byte 0xF2: read, multi-byte, start address 0x32.
  - Then six bytes shifted in, in order X0, X1, Y0, Y1, Z0, Z1.
- UPDATE: one cycle. For each axis, raw = {B1[1:0], B0} (two's complement). The output is {~B1[1], B1[0], B0}, i.e. raw+512, range 0..1023, no saturation needed. All three outputs load in the same cycle, and data_valid pulses in that cycle.
- Bytes are sent and received MSB first. Bits of B1[7:2] are ignored.
- enable falling during READ: the transaction completes and the outputs update. No further reads start.
- A sample tick that arrives while not in IDLE is dropped, not queued.
- Reset in any state, including mid-transaction:
  - the next cycle drives cs_n=1, sclk=1 and sdi=0;
  - the state returns to RST_WAIT and cfg_done=0;
  - the axis outputs return to 512;
  - configuration is redone.
- Reset values: x/y/z_out=512, data_valid=0, cfg_done=0, spi_cs_n=1, spi_sclk=1, spi_sdi=0.

## Timing
- Bit period = 2*CLK_DIV clk cycles. sclk falls at the start of each bit and rises at mid-bit.
- spi_sdi changes on the falling edge. spi_sdo is sampled on the rising edge.
- cs_n goes low CLK_DIV cycles before the first falling edge. It returns high CLK_DIV cycles after the last rising edge.
- cs_n stays high at least 2*CLK_DIV cycles between transactions.
- A write takes 16 bits and a read takes 56 bits, plus CS setup/hold.
- data_valid asserts exactly 1 cycle after cs_n returns high for READ. Outputs are registered and stable until the next UPDATE.

## Configuration
- ACCEL_AVG_EN defined:
  - each axis keeps a 4-entry history of converted samples, all reset to 512;
  - UPDATE shifts in the new sample and outputs (sum of 4) >> 2, using a 12-bit sum and truncating;
  - data_valid timing is unchanged.
- Undefined: outputs are the raw converted sample.

## Test plan
Use CLK_DIV=2 and SAMPLE_DIV=2000, with an SPI slave model.

- Reset, then run: MOSI captures 0x31,0x00 then 0x2D,0x08 in mode 3. cfg_done=1 after the second write. Outputs stay 512 until the first data_valid.
- Slave returns X=FF,01 / Y=00,02 / Z=FF,03 → x_out=1023, y_out=0, z_out=511, with a single data_valid pulse.
- Slave returns all zero bytes → all outputs 512. B1 upper bits set (X1=0xFD) are ignored: x_out=512+256+... per the conversion formula.
- enable=0 → no cs_n activity after the current read and outputs hold. enable=1 → the next read starts at the next sample tick.
- rst asserted in the middle of READ → next cycle cs_n=1, sclk=1, outputs 512, cfg_done=0. The configuration writes repeat.
- ACCEL_AVG_EN, slave X constant 1023 → x_out 639, 767, 895, 1023 on successive data_valid pulses.
